// File: rtl/pwm_pkg.sv
// Shared definitions for the current-setpoint path: level width, default
// top level and the saturating step rule used by the selector.
package pwm_pkg;

  localparam int W_NIVEL = 4;
  localparam logic [W_NIVEL-1:0] NIVEL_MAX = 4'd10;

  // One step of the level register: up or down alone moves by one within
  // [0, tope]; both together, or neither, hold the current value.
  function automatic logic [W_NIVEL-1:0] siguiente_nivel(
    input logic [W_NIVEL-1:0] nivel,
    input logic               sube,
    input logic               baja,
    input logic [W_NIVEL-1:0] tope
  );
    logic [W_NIVEL-1:0] r;
    r = nivel;
    if (sube && !baja && (nivel < tope)) begin
      r = nivel + W_NIVEL'(1);
    end else if (baja && !sube && (nivel != '0)) begin
      r = nivel - W_NIVEL'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sel_corriente_antirrebote.sv
// Button front end: two-flop synchroniser, stability counter and rising-edge
// detector. A level is accepted only after DEB_CYCLES consecutive cycles of
// disagreement with the current debounced level; pulso marks a press.
module antirrebote #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulso
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_FIN = CW'(DEB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          estable;
  logic          estable_d;
  logic [CW-1:0] cnt;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      estable <= 1'b0;
    end else if (sync_b == estable) begin
      cnt <= '0;
    end else if (cnt == CNT_FIN) begin
      estable <= sync_b;
      cnt     <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estable_d <= 1'b0;
    end else begin
      estable_d <= estable;
    end
  end

  assign pulso = estable & ~estable_d;

endmodule

// File: rtl/sel_corriente.sv
// Current-setpoint selector: debounced up/down presses step a saturating
// level register; flags a change pulse and the range limits.
module sel_corriente
  import pwm_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int MAX_LEVEL  = int'(NIVEL_MAX)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [W_NIVEL-1:0] indicadorCoriente,
  output logic               cambio,
  output logic               en_max,
  output logic               en_min
);

  localparam logic [W_NIVEL-1:0] TOPE = W_NIVEL'(MAX_LEVEL);

  logic               pulso_up;
  logic               pulso_down;
  logic [W_NIVEL-1:0] nivel;
  logic [W_NIVEL-1:0] nivel_sig;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_ar_up (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_up),
    .pulso (pulso_up)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_ar_down (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_down),
    .pulso (pulso_down)
  );

  // Arbitrate the two press events into the next level.
  always_comb begin
    nivel_sig = siguiente_nivel(nivel, pulso_up, pulso_down, TOPE);
  end

  // Level register; cambio flags only a real change of the stored value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nivel  <= '0;
      cambio <= 1'b0;
    end else begin
      nivel  <= nivel_sig;
      cambio <= (nivel_sig != nivel);
    end
  end

  assign indicadorCoriente = nivel;
  assign en_max            = (nivel == TOPE);
  assign en_min            = (nivel == '0);

endmodule

// File: tb/tb_sel_corriente.sv
// Bench for sel_corriente with DEB_CYCLES=4, MAX_LEVEL=10: press table,
// change scoreboard, and hand sequences for bounce, simultaneous press and
// resets.
module tb_sel_corriente;

  localparam int DEB = 4;
  localparam int MAXL = 10;

  logic       clk;
  logic       rst_n;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] ind;
  logic       cambio;
  logic       en_max;
  logic       en_min;

  int n_cmp;
  int n_fail;
  bit done;
  int sb[$];
  int nivel_ref;

  typedef struct {
    bit up;
    bit dn;
    int ev;
    bit ec;
  } vec_t;

  vec_t tbl[28];

  sel_corriente #(.DEB_CYCLES(DEB), .MAX_LEVEL(MAXL)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .btn_up            (btn_up),
    .btn_down          (btn_down),
    .indicadorCoriente (ind),
    .cambio            (cambio),
    .en_max            (en_max),
    .en_min            (en_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cambio pulse must match the next expected value in the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!done && cambio === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_unexpected_cambio: got cambio=1 value=%0d, expected no change (t=%0t)",
                   ind, $time);
        end else begin
          chk("sb_value", int'(ind), sb.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

  // One press on the given buttons, held about 20 cycles from E0.
  task automatic do_press(input bit up, input bit dn, input int ev, input bit ec);
    @(posedge clk);
    #1;
    btn_up   = up;
    btn_down = dn;
    if (ec) sb.push_back(ev);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_value", int'(ind), nivel_ref);
    chk("pre_cambio", int'(cambio), 0);
    @(negedge clk);
    chk("value", int'(ind), ev);
    chk("cambio", int'(cambio), int'(ec));
    chk("en_max", int'(en_max), (ev == MAXL) ? 1 : 0);
    chk("en_min", int'(en_min), (ev == 0) ? 1 : 0);
    @(negedge clk);
    chk("cambio_one_cycle", int'(cambio), 0);
    repeat (13) @(negedge clk);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (10) @(negedge clk);
    chk("after_release", int'(ind), ev);
    nivel_ref = ev;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    done      = 1'b0;
    nivel_ref = 0;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    rst_n     = 1'b1;

    for (int i = 0; i < 12; i++) tbl[i] = '{1'b1, 1'b0, (i < 10) ? i + 1 : 10, i < 10};
    for (int i = 0; i < 11; i++) tbl[12 + i] = '{1'b0, 1'b1, (i < 10) ? 9 - i : 0, i < 10};
    for (int i = 0; i < 5; i++) tbl[23 + i] = '{1'b1, 1'b0, i + 1, 1'b1};

    // Asynchronous reset with no clock edge in between.
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_value", int'(ind), 0);
    chk("rst_cambio", int'(cambio), 0);
    chk("rst_en_max", int'(en_max), 0);
    chk("rst_en_min", int'(en_min), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Bounce: 3-cycle highs, 2-cycle lows, never long enough to accept.
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      btn_up = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      btn_up = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    repeat (12) @(negedge clk);
    chk("bounce_value", int'(ind), 0);
    chk("bounce_en_min", int'(en_min), 1);

    // Table: saturation up to 10, down to 0, then up to 5.
    for (int i = 0; i < 28; i++) begin
      do_press(tbl[i].up, tbl[i].dn, tbl[i].ev, tbl[i].ec);
    end

    // Simultaneous press at 5, then drop down while up stays held.
    @(posedge clk);
    #1;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("simul_value", int'(ind), 5);
    chk("simul_cambio", int'(cambio), 0);
    repeat (5) @(negedge clk);
    btn_down = 1'b0;
    repeat (16) @(negedge clk);
    chk("held_no_repeat", int'(ind), 5);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_release", int'(ind), 5);

    do_press(1'b1, 1'b0, 6, 1'b1);
    do_press(1'b1, 1'b0, 7, 1'b1);

    // Reset mid-debounce at value 7 with up held (cnt=2 after E3).
    @(posedge clk);
    #1;
    btn_up = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_midrst_value", int'(ind), 7);
    rst_n = 1'b0;
    #1;
    chk("midrst_value", int'(ind), 0);
    chk("midrst_cambio", int'(cambio), 0);
    chk("midrst_en_min", int'(en_min), 1);
    chk("midrst_en_max", int'(en_max), 0);
    repeat (2) @(negedge clk);
    sb.push_back(1);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("postrst_pre_value", int'(ind), 0);
    @(negedge clk);
    chk("postrst_value", int'(ind), 1);
    chk("postrst_cambio", int'(cambio), 1);
    chk("postrst_en_min", int'(en_min), 0);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    chk("postrst_hold", int'(ind), 1);

    done = 1'b1;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sel_corriente.md
# sel_corriente

Button-driven current-setpoint selector: produces the 4-bit current indicator code (0–10) consumed by the current-digit decoder and the PWM duty logic. Two raw push-buttons (up/down) are synchronised and debounced, then edge-detected. The resulting press events step a saturating level register. The block flags level changes and the range limits to the display/control path.

## Interface
- `DEB_CYCLES`, default 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz); must be ≥1.
- `MAX_LEVEL`, default 10: highest legal indicator code; must be ≤15.
- `clk` in 1: single system clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `btn_up` in 1: raw up push-button, asynchronous to `clk`, active-high.
- `btn_down` in 1: raw down push-button, asynchronous to `clk`, active-high.
- `indicadorCoriente` out 4: current setpoint code, 0..MAX_LEVEL.
- `cambio` out 1: one-cycle pulse, high in the first cycle a new `indicadorCoriente` value is visible.
- `en_max` out 1: high while `indicadorCoriente` == MAX_LEVEL.
- `en_min` out 1: high while `indicadorCoriente` == 0.

## Operation
- Reset values: `indicadorCoriente`=0, `cambio`=0, `en_max`=0, `en_min`=1. All synchroniser, debounce and edge registers are 0.
- Per button path:
  - 2-flop synchroniser, then debounced level `estable`.
  - Counter `cnt` of width $clog2(DEB_CYCLES+1) increments each cycle the synchronised level differs from `estable`.
  - `cnt` clears to 0 on any cycle the synchronised level equals `estable`.
  - When `cnt` == DEB_CYCLES-1 and the levels still differ: `estable` takes the synchronised level and `cnt` clears.
- Press event `pulso` = `estable` & ~`estable_d`, where `estable_d` is `estable` delayed one cycle. A release generates no event.
- Level register updates on the cycle after a `pulso`:
  - up only: increment if < MAX_LEVEL, else hold.
  - down only: decrement if > 0, else hold.
  - up and down events in the same cycle: hold.
- No wrap-around: increment at MAX_LEVEL and decrement at 0 leave the value unchanged, and `cambio` stays 0.
- `cambio` asserts only when the stored value actually changes.
- A held button yields exactly one step; there is no auto-repeat.
- Glitches shorter than DEB_CYCLES cycles never change `estable`.
- `en_max`/`en_min` are decoded from the level register (combinational from state, glitch-free with respect to inputs).

## Timing
- Raw button high first sampled at edge E0: synchroniser output high after E1, `estable` high after edge E1+DEB_CYCLES, `pulso` high during the following cycle.
- `indicadorCoriente` takes its new value at edge E0+DEB_CYCLES+2. `cambio` is high for exactly that one cycle.
- Minimum spacing between accepted presses on one button: 2·DEB_CYCLES cycles, covering the press and release debounce.
- Reset mid-debounce or mid-press: all state is cleared immediately. After release of `rst_n`, a button still held counts as a new press once it is debounced.

## Structure
- Shared package `pwm_pkg`:
  - constant `NIVEL_MAX` = 4'd10, the default for MAX_LEVEL.
  - localparam `W_NIVEL` = 4.
  - These are shared with the current-digit decoder and the PWM duty table.
- Sub-module `antirrebote` (parameter DEB_CYCLES; ports `clk`, `rst_n`, `btn`, `pulso`) contains the synchroniser, debounce counter and edge detector. It is instantiated twice.
- The top level holds the level register, the step arbitration, `cambio`, and the limit decode.

## Test plan
All scenarios use DEB_CYCLES=4 and MAX_LEVEL=10.
- Reset: assert `rst_n`=0 mid-cycle. Outputs go to 0/0/0/1 immediately, with no clock needed.
- Single up press: `btn_up` high for 20 cycles from E0. `indicadorCoriente` 0→1 at edge E0+6, `cambio` high for 1 cycle, `en_min` drops. Release produces no further change.
- Bounce rejection: `btn_up` toggles with high pulses of 3 cycles and low gaps of 2 cycles for 30 cycles. `indicadorCoriente` stays 0 and `cambio` never asserts.
- Saturation: 12 clean up presses give value 10, `en_max`=1, and `cambio` only on the first 10. Then 11 down presses give value 0, `en_min`=1, and no `cambio` on the 11th.
- Simultaneous press: at value 5, `btn_up` and `btn_down` rise on the same edge. Value stays 5 and `cambio`=0. Then releasing down and keeping up held gives no change, because a held button does not repeat.
- Reset mid-operation: at value 7 with `btn_up` held and `cnt`=2, pulse `rst_n` low. Value becomes 0 at once. After reset release with up still held, value becomes 1 six cycles after the first post-reset sampling edge.
